// File: rtl/csr_regfile_if.sv
// csr_regfile_if
//   Bundles every pipeline/write-back facing signal of the machine-mode CSR
//   register file. clk_i/rst_i stay as plain module ports.
//   master : pipeline / write-back side (drives requests, reads taps)
//   slave  : csr_regfile (drives read data and field taps)
//   Signals:
//     csr_ridx_i / csr_rdata_o / csr_ilegl_o      combinational read port
//     wb_csr_wen_i / wb_csr_idx_i / wb_csr_wdata_i generic CSR write
//     mcause_*, mtval_*, mepc_*                    trap-side writes
//     mstatus_mie_set_i / mstatus_mie_clear_i      trap entry / mret
//     ext_irq_i, tmr_irq_i, sft_irq_i              interrupt levels
//     instret_i                                    retire strobe
//     *_rdata_o taps                               fields used by write-back

`ifndef XLEN
`define XLEN 64
`endif

interface csr_regfile_if;
  logic [11:0]       csr_ridx_i;
  logic [`XLEN-1:0]  csr_rdata_o;
  logic              csr_ilegl_o;

  logic              wb_csr_wen_i;
  logic [11:0]       wb_csr_idx_i;
  logic [`XLEN-1:0]  wb_csr_wdata_i;

  logic              mcause_wen_i;
  logic [`XLEN-1:0]  mcause_wdata_i;
  logic              mtval_wen_i;
  logic [`XLEN-1:0]  mtval_wdata_i;
  logic              mepc_wen_i;
  logic [`XLEN-1:0]  mepc_wdata_i;

  logic              mstatus_mie_set_i;
  logic              mstatus_mie_clear_i;

  logic              ext_irq_i;
  logic              tmr_irq_i;
  logic              sft_irq_i;
  logic              instret_i;

  logic              mstatus_mie_rdata_o;
  logic              mie_meie_rdata_o;
  logic              mie_mtie_rdata_o;
  logic              mie_msie_rdata_o;
  logic              mip_meip_rdata_o;
  logic              mip_mtip_rdata_o;
  logic              mip_msip_rdata_o;
  logic [`XLEN-1:0]  mtvec_rdata_o;
  logic [`XLEN-1:0]  mepc_rdata_o;

  modport master (
    output csr_ridx_i,
    input  csr_rdata_o, csr_ilegl_o,
    output wb_csr_wen_i, wb_csr_idx_i, wb_csr_wdata_i,
    output mcause_wen_i, mcause_wdata_i, mtval_wen_i, mtval_wdata_i,
    output mepc_wen_i, mepc_wdata_i,
    output mstatus_mie_set_i, mstatus_mie_clear_i,
    output ext_irq_i, tmr_irq_i, sft_irq_i, instret_i,
    input  mstatus_mie_rdata_o,
    input  mie_meie_rdata_o, mie_mtie_rdata_o, mie_msie_rdata_o,
    input  mip_meip_rdata_o, mip_mtip_rdata_o, mip_msip_rdata_o,
    input  mtvec_rdata_o, mepc_rdata_o
  );

  modport slave (
    input  csr_ridx_i,
    output csr_rdata_o, csr_ilegl_o,
    input  wb_csr_wen_i, wb_csr_idx_i, wb_csr_wdata_i,
    input  mcause_wen_i, mcause_wdata_i, mtval_wen_i, mtval_wdata_i,
    input  mepc_wen_i, mepc_wdata_i,
    input  mstatus_mie_set_i, mstatus_mie_clear_i,
    input  ext_irq_i, tmr_irq_i, sft_irq_i, instret_i,
    output mstatus_mie_rdata_o,
    output mie_meie_rdata_o, mie_mtie_rdata_o, mie_msie_rdata_o,
    output mip_meip_rdata_o, mip_mtip_rdata_o, mip_msip_rdata_o,
    output mtvec_rdata_o, mepc_rdata_o
  );
endinterface

// File: rtl/csr_regfile.sv
// csr_regfile
//   Machine-mode CSR register file: mstatus (MIE/MPIE), misa, mie, mtvec,
//   mscratch, mepc, mcause, mtval, mip, mhartid and optionally mcycle /
//   minstret. Combinational read port, generic write-back writes, trap-side
//   writes with higher priority, and field taps for trap decisions.
//   Ports:
//     clk_i  core clock
//     rst_i  synchronous active-high reset
//     bus    csr_regfile_if.slave (read port, write ports, irqs, taps)
//   Parameters:
//     RESET_MTVEC  mtvec after reset (bits [1:0] must be 0)
//     HART_ID      value returned by mhartid
//   Build option:
//     CSR_COUNTERS_EN  when defined, mcycle/minstret flops are built;
//                      otherwise 0xB00/0xB02 read 0 and drop writes.

`ifndef XLEN
`define XLEN 64
`endif

module csr_regfile #(
  parameter logic [`XLEN-1:0] RESET_MTVEC = 64'h0000_0000_8000_0000,
  parameter logic [`XLEN-1:0] HART_ID     = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  csr_regfile_if.slave   bus
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MIP      = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  // MXL = 2 (64-bit) in the top two bits, extension I at bit 8.
  localparam logic [`XLEN-1:0] MISA_VAL = 64'h8000_0000_0000_0100;

  logic             mstatus_mie;
  logic             mstatus_mpie;
  logic             mie_msie, mie_mtie, mie_meie;
  logic             mip_msip, mip_mtip, mip_meip;
  logic [`XLEN-1:0] mtvec;
  logic [`XLEN-1:0] mscratch;
  logic [`XLEN-1:0] mepc;
  logic [`XLEN-1:0] mcause;
  logic [`XLEN-1:0] mtval;
  logic [`XLEN-1:0] mcycle_val;
  logic [`XLEN-1:0] minstret_val;

  logic             gen_wen;
  logic [11:0]      gen_idx;
  logic [`XLEN-1:0] gen_wdata;

  assign gen_wen   = bus.wb_csr_wen_i;
  assign gen_idx   = bus.wb_csr_idx_i;
  assign gen_wdata = bus.wb_csr_wdata_i;

  // Within the non-reset branch, later assignments win, so statements are
  // ordered lowest priority first: generic write, then trap-side write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_msie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_msip     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec        <= RESET_MTVEC;
      mscratch     <= '0;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
    end else begin
      mip_msip <= bus.sft_irq_i;
      mip_mtip <= bus.tmr_irq_i;
      mip_meip <= bus.ext_irq_i;

      if (gen_wen) begin
        case (gen_idx)
          ADDR_MSTATUS: begin
            mstatus_mie  <= gen_wdata[3];
            mstatus_mpie <= gen_wdata[7];
          end
          ADDR_MIE: begin
            mie_msie <= gen_wdata[3];
            mie_mtie <= gen_wdata[7];
            mie_meie <= gen_wdata[11];
          end
          ADDR_MTVEC:    mtvec    <= {gen_wdata[`XLEN-1:2], 2'b00};
          ADDR_MSCRATCH: mscratch <= gen_wdata;
          ADDR_MEPC:     mepc     <= {gen_wdata[`XLEN-1:2], 2'b00};
          ADDR_MCAUSE:   mcause   <= gen_wdata;
          ADDR_MTVAL:    mtval    <= gen_wdata;
          default: ;
        endcase
      end

      if (bus.mcause_wen_i) mcause <= bus.mcause_wdata_i;
      if (bus.mtval_wen_i)  mtval  <= bus.mtval_wdata_i;
      if (bus.mepc_wen_i)   mepc   <= {bus.mepc_wdata_i[`XLEN-1:2], 2'b00};

      // Trap entry beats mret when both fire together.
      if (bus.mstatus_mie_set_i) begin
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (bus.mstatus_mie_clear_i) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A generic write replaces that cycle's increment; wrap is natural.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcycle_val   <= '0;
      minstret_val <= '0;
    end else begin
      if (gen_wen && gen_idx == ADDR_MCYCLE) mcycle_val <= gen_wdata;
      else                                   mcycle_val <= mcycle_val + 1'b1;

      if (gen_wen && gen_idx == ADDR_MINSTRET) minstret_val <= gen_wdata;
      else if (bus.instret_i)                  minstret_val <= minstret_val + 1'b1;
    end
  end
`else
  logic unused_instret;
  assign unused_instret = bus.instret_i;
  assign mcycle_val     = '0;
  assign minstret_val   = '0;
`endif

  always_comb begin
    bus.csr_rdata_o = '0;
    bus.csr_ilegl_o = 1'b0;
    case (bus.csr_ridx_i)
      ADDR_MSTATUS: begin
        bus.csr_rdata_o[3]     = mstatus_mie;
        bus.csr_rdata_o[7]     = mstatus_mpie;
        bus.csr_rdata_o[12:11] = 2'b11;
      end
      ADDR_MISA: bus.csr_rdata_o = MISA_VAL;
      ADDR_MIE: begin
        bus.csr_rdata_o[3]  = mie_msie;
        bus.csr_rdata_o[7]  = mie_mtie;
        bus.csr_rdata_o[11] = mie_meie;
      end
      ADDR_MTVEC:    bus.csr_rdata_o = mtvec;
      ADDR_MSCRATCH: bus.csr_rdata_o = mscratch;
      ADDR_MEPC:     bus.csr_rdata_o = mepc;
      ADDR_MCAUSE:   bus.csr_rdata_o = mcause;
      ADDR_MTVAL:    bus.csr_rdata_o = mtval;
      ADDR_MIP: begin
        bus.csr_rdata_o[3]  = mip_msip;
        bus.csr_rdata_o[7]  = mip_mtip;
        bus.csr_rdata_o[11] = mip_meip;
      end
      ADDR_MCYCLE:   bus.csr_rdata_o = mcycle_val;
      ADDR_MINSTRET: bus.csr_rdata_o = minstret_val;
      ADDR_MHARTID:  bus.csr_rdata_o = HART_ID;
      default:       bus.csr_ilegl_o = 1'b1;
    endcase
  end

  assign bus.mstatus_mie_rdata_o = mstatus_mie;
  assign bus.mie_meie_rdata_o    = mie_meie;
  assign bus.mie_mtie_rdata_o    = mie_mtie;
  assign bus.mie_msie_rdata_o    = mie_msie;
  assign bus.mip_meip_rdata_o    = mip_meip;
  assign bus.mip_mtip_rdata_o    = mip_mtip;
  assign bus.mip_msip_rdata_o    = mip_msip;
  assign bus.mtvec_rdata_o       = mtvec;
  assign bus.mepc_rdata_o        = mepc;

endmodule

// File: doc/csr_regfile.md
# csr_regfile

Machine-mode CSR register file for the pipelined core. It is the CSR end of the write-back trap interface and holds mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch and the cycle/instret counters. It accepts generic CSR writes and trap-side writes from write-back. It supplies a combinational read port to the pipeline, plus the individual fields that write-back uses to decide traps and redirect targets.

## Interface
- RESET_MTVEC, 64'h0000_0000_8000_0000: mtvec value after reset; bits [1:0] must be 0.
- HART_ID, 0: value returned by mhartid.
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous, active-high reset.
- csr_ridx_i  input  12  read address.
- csr_rdata_o  output  `XLEN  read data; combinational from current state.
- csr_ilegl_o  output  1  asserted when csr_ridx_i is not an implemented address.
- wb_csr_wen_i / wb_csr_idx_i / wb_csr_wdata_i  input  1/12/`XLEN  generic CSR write from write-back.
- mcause_wen_i / mcause_wdata_i, mtval_wen_i / mtval_wdata_i, mepc_wen_i / mepc_wdata_i  input  1/`XLEN each  trap-side writes.
- mstatus_mie_set_i  input  1  trap entry: MPIE<=MIE, MIE<=0.
- mstatus_mie_clear_i  input  1  mret: MIE<=MPIE, MPIE<=1.
- ext_irq_i, tmr_irq_i, sft_irq_i  input  1 each  interrupt request levels.
- instret_i  input  1  one instruction retired this cycle.
- mstatus_mie_rdata_o, mie_meie/mtie/msie_rdata_o, mip_meip/mtip/msip_rdata_o  output  1 each  field taps.
- mtvec_rdata_o, mepc_rdata_o  output  `XLEN  register taps.

## Operation
- Address map:
  - mstatus 0x300: MIE bit 3, MPIE bit 7, MPP [12:11] reads 2'b11, other bits read 0.
  - misa 0x301: read-only constant, RV64I.
  - mie 0x304: MSIE 3, MTIE 7, MEIE 11; other bits read 0.
  - mtvec 0x305.
  - mscratch 0x340.
  - mepc 0x341.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: MSIP 3, MTIP 7, MEIP 11; read-only.
  - mcycle 0xB00.
  - minstret 0xB02.
  - mhartid 0xF14: read-only.
- Writes to read-only or unimplemented addresses are silently dropped.
- mtvec and mepc force bits [1:0] to 0 on every write path.
- mip is a register sampled from the irq inputs each cycle, so mip_*_rdata_o lags the inputs by 1 cycle.
- Write priority, per register, highest first:
  1. Reset.
  2. Trap-side write (mcause_wen_i, mtval_wen_i, mepc_wen_i, mstatus_mie_set_i/clear_i).
  3. Generic write.
  4. Counter increment.
- If mstatus_mie_set_i and mstatus_mie_clear_i are both asserted, set wins.
- mcycle increments every cycle. minstret increments when instret_i is high. A generic write to either counter replaces that cycle's increment, and the written value is seen on the following cycle.
- Counters wrap from 2^64-1 to 0.

## Timing
- Read is combinational. A read in the same cycle as a write to the same address returns the old value; there is no forwarding.
- All writes take effect at the next rising edge of clk_i.
- Reset values:
  - mtvec = RESET_MTVEC.
  - MIE = 0, MPIE = 0.
  - mie, mip, mepc, mcause, mtval, mscratch, mcycle, minstret all 0.
  - Every *_rdata_o output is therefore 0 except mtvec_rdata_o, which equals RESET_MTVEC.
- Reset asserted mid-operation overrides any write or increment in the same cycle.
- The first increment of mcycle is on the first edge after rst_i deasserts.

## Configuration
- CSR_COUNTERS_EN defined: mcycle and minstret are implemented as described.
- CSR_COUNTERS_EN undefined: no counter flops are built. 0xB00 and 0xB02 read 0, writes to them are dropped, and csr_ilegl_o stays 0 for those addresses. instret_i is ignored.

## Test plan
- Reset → mtvec_rdata_o = 0x80000000. Read 0x300 → 0x1800. Read 0x7C0 → csr_ilegl_o = 1.
- Generic write 0x305 ← 0x1003 → next cycle mtvec_rdata_o = 0x1000. Write 0x344 ← 0x888 → mip still reads 0.
- MIE = 1, then pulse mstatus_mie_set_i → MIE = 0, MPIE = 1. Then pulse mstatus_mie_clear_i → MIE = 1, MPIE = 1.
- Same cycle: mepc_wen_i with 0x200 and generic write 0x341 ← 0x300 → mepc = 0x200.
- Assert tmr_irq_i at cycle N → mip_mtip_rdata_o = 1 from N+1. Deassert → 0 one cycle later.
- With CSR_COUNTERS_EN:
  - Write 0xB00 ← 0xFFFF_FFFF_FFFF_FFFF → following cycle reads that value, the next cycle reads 0.
  - Two instret_i pulses → minstret advances by 2.
